// File: rtl/controlador_dma_disco_pkg.sv
// Shared constants and state encoding for the disk DMA controller.
package controlador_dma_disco_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned EXT_W         = WORD_W + 1;
  localparam int unsigned DISK_SIZE_DEF = 500;
  localparam int unsigned MEM_SIZE_DEF  = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } estado_t;

endpackage

// File: rtl/mux_porta_disco.sv
// Disk-port multiplexer: the CPU always wins over the DMA engine.
module mux_porta_disco
  import controlador_dma_disco_pkg::*;
(
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [WORD_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  input  logic              dma_we_i,
  input  logic [WORD_W-1:0] dma_addr_i,
  input  logic [WORD_W-1:0] dma_data_i,
  output logic              disk_we_o,
  output logic [WORD_W-1:0] disk_addr_o,
  output logic [WORD_W-1:0] disk_datain_o
);

  always_comb begin
    disk_we_o     = dma_we_i;
    disk_addr_o   = dma_addr_i;
    disk_datain_o = dma_data_i;
    if (cpu_req_i) begin
      disk_we_o     = cpu_we_i;
      disk_addr_o   = cpu_addr_i;
      disk_datain_o = cpu_data_i;
    end
  end

endmodule

// File: rtl/controlador_dma_disco.sv
// Disk <-> main-memory DMA engine, one word per cycle, stalled by CPU disk accesses.
module controlador_dma_disco
  import controlador_dma_disco_pkg::*;
#(
  parameter int unsigned DISK_SIZE = DISK_SIZE_DEF,
  parameter int unsigned MEM_SIZE  = MEM_SIZE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [WORD_W-1:0] disk_base,
  input  logic [WORD_W-1:0] mem_base,
  input  logic [WORD_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [WORD_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_data,
  output logic              disk_we,
  output logic [WORD_W-1:0] disk_addr,
  output logic [WORD_W-1:0] disk_datain,
  input  logic [WORD_W-1:0] disk_dataout,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_datain,
  input  logic [WORD_W-1:0] mem_dataout
);

  estado_t           state_q, state_d;
  logic              dir_q, dir_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] disk_base_q, disk_base_d;
  logic [WORD_W-1:0] mem_base_q, mem_base_d;
  logic [WORD_W-1:0] len_q, len_d;
  logic [WORD_W-1:0] i_q, i_d;

  logic [EXT_W-1:0]  disk_end, mem_end;
  logic              range_bad, last_word;
  logic              dma_disk_we;
  logic [WORD_W-1:0] dma_disk_addr;

  // 33-bit end addresses so an oversized request can never wrap past the check
  assign disk_end  = {1'b0, disk_base} + {1'b0, length};
  assign mem_end   = {1'b0, mem_base} + {1'b0, length};
  assign range_bad = (disk_end > EXT_W'(DISK_SIZE)) || (mem_end > EXT_W'(MEM_SIZE));
  assign last_word = (i_q == (len_q - WORD_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      disk_base_q <= '0;
      mem_base_q  <= '0;
      len_q       <= '0;
      i_q         <= '0;
    end else begin
      dir_q       <= dir_d;
      err_q       <= err_d;
      disk_base_q <= disk_base_d;
      mem_base_q  <= mem_base_d;
      len_q       <= len_d;
      i_q         <= i_d;
    end
  end

  // A CPU request freezes the engine; FIN still retires so done stays a single pulse
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    err_d       = err_q;
    disk_base_d = disk_base_q;
    mem_base_d  = mem_base_q;
    len_d       = len_q;
    i_d         = i_q;
    case (state_q)
      IDLE: begin
        if (start && !cpu_req) begin
          dir_d       = dir;
          disk_base_d = disk_base;
          mem_base_d  = mem_base;
          len_d       = length;
          i_d         = '0;
          err_d       = range_bad;
          if (range_bad || (length == '0)) state_d = FIN;
          else                             state_d = XFER;
        end
      end
      XFER: begin
        if (!cpu_req) begin
          i_d = i_q + WORD_W'(1);
          if (last_word) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == XFER);
    done          = (state_q == FIN);
    err           = err_q;
    mem_we        = (state_q == XFER) && !dir_q && !cpu_req;
    dma_disk_we   = (state_q == XFER) && dir_q;
    mem_addr      = mem_base_q + i_q;
    dma_disk_addr = disk_base_q + i_q;
    mem_datain    = disk_dataout;
  end

  mux_porta_disco u_mux (
    .cpu_req_i     (cpu_req),
    .cpu_we_i      (cpu_we),
    .cpu_addr_i    (cpu_addr),
    .cpu_data_i    (cpu_data),
    .dma_we_i      (dma_disk_we),
    .dma_addr_i    (dma_disk_addr),
    .dma_data_i    (mem_dataout),
    .disk_we_o     (disk_we),
    .disk_addr_o   (disk_addr),
    .disk_datain_o (disk_datain)
  );

endmodule

// File: tb/tb_controlador_dma_disco.sv
// Bench for controlador_dma_disco: vector table of transfers, write scoreboard, corner sequences.
module tb_controlador_dma_disco;

  localparam int unsigned DSZ = 500;
  localparam int unsigned MSZ = 1024;

  logic        clk = 1'b0;
  logic        reset, start, dir;
  logic [31:0] disk_base, mem_base, length;
  logic        busy, done, err;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_data;
  logic        disk_we, mem_we;
  logic [31:0] disk_addr, disk_datain, disk_dataout;
  logic [31:0] mem_addr, mem_datain, mem_dataout;

  always #5 clk = ~clk;

  controlador_dma_disco #(.DISK_SIZE(DSZ), .MEM_SIZE(MSZ)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir),
    .disk_base(disk_base), .mem_base(mem_base), .length(length),
    .busy(busy), .done(done), .err(err),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .disk_we(disk_we), .disk_addr(disk_addr), .disk_datain(disk_datain),
    .disk_dataout(disk_dataout),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout)
  );

  typedef struct {
    logic        dir;
    logic [31:0] disk_base;
    logic [31:0] mem_base;
    logic [31:0] length;
    logic        exp_err;
    int          exp_busy;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  mq[$];
  wr_t  dq[$];
  logic [31:0] disk_m [DSZ];
  logic [31:0] mem_m  [MSZ];
  logic preload;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  logic last_err = 1'b0;
  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Disk and memory models: write at posedge, read data presented at negedge
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < int'(DSZ); k++) disk_m[k] <= 32'h1000 + 32'(k);
      for (int k = 0; k < int'(MSZ); k++) mem_m[k]  <= 32'h2000 + 32'(k);
      disk_m[64] <= 32'd5; disk_m[65] <= 32'd6; disk_m[66] <= 32'd7; disk_m[67] <= 32'd8;
      mem_m[10]  <= 32'hAA; mem_m[11] <= 32'hBB;
    end else begin
      if (disk_we && disk_addr < DSZ) disk_m[disk_addr[8:0]] <= disk_datain;
      if (mem_we && mem_addr < MSZ)   mem_m[mem_addr[9:0]]   <= mem_datain;
    end
  end

  always @(negedge clk) begin
    disk_dataout <= (disk_addr < DSZ) ? disk_m[disk_addr[8:0]] : 32'h0;
    mem_dataout  <= (mem_addr < MSZ)  ? mem_m[mem_addr[9:0]]   : 32'h0;
  end

  // Scoreboard monitor, sampled mid-low-phase
  always @(negedge clk) begin
    wr_t e;
    #2;
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; last_err = err; end
    if (mem_we) begin
      if (mq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_mem_write: addr %0d data %0h, none expected", mem_addr, mem_datain);
      end else begin
        e = mq.pop_front();
        chk("mem_wr_addr", mem_addr, e.addr);
        chk("mem_wr_data", mem_datain, e.data);
      end
    end
    if (disk_we) begin
      if (dq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_disk_write: addr %0d data %0h, none expected", disk_addr, disk_datain);
      end else begin
        e = dq.pop_front();
        chk("disk_wr_addr", disk_addr, e.addr);
        chk("disk_wr_data", disk_datain, e.data);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int cpu_cyc);
    wr_t         w;
    logic [31:0] a;
    int          d0, b0;
    bit          got;
    if (!v.exp_err) begin
      for (int k = 0; k < int'(v.length); k++) begin
        if (v.dir) begin
          a = v.mem_base + 32'(k);
          w.addr = v.disk_base + 32'(k);
          w.data = mem_m[a[9:0]];
          dq.push_back(w);
        end else begin
          a = v.disk_base + 32'(k);
          w.addr = v.mem_base + 32'(k);
          w.data = disk_m[a[8:0]];
          mq.push_back(w);
        end
      end
    end
    @(posedge clk); #1;
    d0 = done_cnt; b0 = busy_cnt;
    dir = v.dir; disk_base = v.disk_base; mem_base = v.mem_base; length = v.length;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (c == cpu_cyc) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd400; cpu_data = 32'h55;
        w.addr = 32'd400; w.data = 32'h55;
        dq.push_back(w);
      end
      @(posedge clk); #1;
      cpu_req = 1'b0; cpu_we = 1'b0;
      if (done_cnt != d0) got = 1'b1;
    end
    @(posedge clk); #1;
    chk("done_seen", 32'(got), 32'd1);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("busy_cycles", 32'(busy_cnt - b0), 32'(v.exp_busy));
    chk("err_with_done", 32'(last_err), 32'(v.exp_err));
    chk("mem_queue_drained", 32'(mq.size()), 32'd0);
    chk("disk_queue_drained", 32'(dq.size()), 32'd0);
  endtask

  initial begin
    int d0, b0;
    vec_t v;
    vecs[0] = '{1'b0, 32'd64,  32'd0,    32'd4, 1'b0, 4};
    vecs[1] = '{1'b1, 32'd300, 32'd10,   32'd2, 1'b0, 2};
    vecs[2] = '{1'b0, 32'd498, 32'd0,    32'd4, 1'b1, 0};
    vecs[3] = '{1'b0, 32'd0,   32'd0,    32'd0, 1'b0, 0};
    vecs[4] = '{1'b1, 32'd0,   32'd1020, 32'd4, 1'b0, 4};
    vecs[5] = '{1'b1, 32'd0,   32'd1021, 32'd4, 1'b1, 0};
    vecs[6] = '{1'b0, 32'd496, 32'd100,  32'd4, 1'b0, 4};

    reset = 1'b1; preload = 1'b1; start = 1'b0; dir = 1'b0;
    disk_base = '0; mem_base = '0; length = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_disk_we", 32'(disk_we), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      if (i > 0 && vecs[i-1].exp_err) chk("err_hold", 32'(err), 32'd1);
      run_vec(vecs[i], 0);
    end
    chk("mem0", mem_m[0], 32'd5);
    chk("mem1", mem_m[1], 32'd6);
    chk("mem2", mem_m[2], 32'd7);
    chk("mem3", mem_m[3], 32'd8);
    chk("disk300", disk_m[300], 32'hAA);
    chk("disk301", disk_m[301], 32'hBB);
    chk("mem100", mem_m[100], 32'h1000 + 32'd496);
    chk("disk3", disk_m[3], 32'h2000 + 32'd1023);

    // CPU access steals the 2nd transfer cycle
    v = '{1'b0, 32'd64, 32'd200, 32'd4, 1'b0, 5};
    run_vec(v, 2);
    chk("cpu_disk400", disk_m[400], 32'h55);
    chk("cpu_mem200", mem_m[200], 32'd5);
    chk("cpu_mem201", mem_m[201], 32'd6);
    chk("cpu_mem202", mem_m[202], 32'd7);
    chk("cpu_mem203", mem_m[203], 32'd8);

    // start held into the FIN cycle must be ignored
    @(posedge clk); #1;
    d0 = done_cnt; b0 = busy_cnt;
    dir = 1'b0; disk_base = 32'd0; mem_base = 32'd0; length = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    chk("fin_done_now", 32'(done), 32'd1);
    disk_base = 32'd64; mem_base = 32'd700; length = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("fin_start_busy", 32'(busy_cnt - b0), 32'd0);
    chk("fin_start_done", 32'(done_cnt - d0), 32'd1);

    // reset mid-transfer after two words
    v = '{1'b0, 32'd64, 32'd500, 32'd4, 1'b0, 4};
    for (int k = 0; k < 2; k++) begin
      wr_t w;
      w.addr = 32'd500 + 32'(k);
      w.data = disk_m[64 + k];
      mq.push_back(w);
    end
    @(posedge clk); #1;
    d0 = done_cnt;
    dir = v.dir; disk_base = v.disk_base; mem_base = v.mem_base; length = v.length; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_queue", 32'(mq.size()), 32'd0);
    chk("abort_mem500", mem_m[500], 32'd5);
    chk("abort_mem501", mem_m[501], 32'd6);
    chk("abort_mem502", mem_m[502], 32'h2000 + 32'd502);
    chk("abort_mem503", mem_m[503], 32'h2000 + 32'd503);

    v = '{1'b0, 32'd64, 32'd600, 32'd4, 1'b0, 4};
    run_vec(v, 0);
    chk("restart_mem603", mem_m[603], 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/controlador_dma_disco.md
CONTROLADOR_DMA_DISCO -- requirements
Module: controlador_dma_disco

Interface
REQ-001 SHALL have parameter DISK_SIZE, default 500, meaning number of 32-bit disk words.
REQ-002 SHALL have parameter MEM_SIZE, default 1024, meaning number of 32-bit main-memory words.
REQ-003 SHALL have port clk, input, 1, the single clock; reset is asynchronous and active-high.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle transfer request.
REQ-006 SHALL have port dir, input, 1, transfer direction: 0 = disk->memory, 1 = memory->disk.
REQ-007 SHALL have ports disk_base, mem_base and length, each input, 32, transfer parameters sampled with start.
REQ-008 SHALL have ports busy, done and err, each output, 1, status.
REQ-009 SHALL have ports cpu_req, input, 1; cpu_we, input, 1; cpu_addr, input, 32; cpu_data, input, 32; these carry CPU direct disk access (ldk/sim).
REQ-010 SHALL have ports disk_we, output, 1; disk_addr, output, 32; disk_datain, output, 32; disk_dataout, input, 32; these form the disk port.
REQ-011 SHALL have ports mem_we, output, 1; mem_addr, output, 32; mem_datain, output, 32; mem_dataout, input, 32; these form the memory port.

Function
REQ-012 SHALL implement states IDLE, XFER and FIN.
REQ-013 In IDLE, start=1 at a posedge SHALL latch dir, disk_base, mem_base and length into registers, clear the word counter i, and move to XFER. start SHALL be ignored outside IDLE.
REQ-014 If disk_base+length > DISK_SIZE or mem_base+length > MEM_SIZE, computed in 33-bit arithmetic, the start posedge SHALL move directly to FIN with err set and perform no transfer.
REQ-015 If length=0, the start posedge SHALL move directly to FIN with err clear.
REQ-016 In XFER with cpu_req=0, the block SHALL transfer exactly one word per cycle:
- disk_addr = disk_base+i and mem_addr = mem_base+i, both combinational from registers.
- When dir=0: mem_we=1, mem_datain=disk_dataout, disk_we=0. The disk provides read data at negedge.
- When dir=1: disk_we=1, disk_datain=mem_dataout, mem_we=0.
- i SHALL increment at the posedge.
REQ-017 In XFER, when the posedge completes word i = length-1, the state SHALL move to FIN.
REQ-018 CPU has absolute priority. Whenever cpu_req=1, in any state:
- disk_addr=cpu_addr, disk_we=cpu_we, disk_datain=cpu_data.
- mem_we=0.
- i and all DMA registers SHALL hold, so the DMA stalls exactly that cycle.
REQ-019 When cpu_req=0 and the state is not XFER, disk_we=0 and mem_we=0. Address outputs are don't-care but SHALL be driven as disk_base+i and mem_base+i.
REQ-020 busy SHALL be 1 exactly while the state is XFER.
REQ-021 done SHALL be 1 for exactly one cycle, while the state is FIN; the next posedge SHALL return to IDLE.
REQ-022 err SHALL be valid alongside done and SHALL hold its value until the next accepted start.
REQ-023 A start asserted in the FIN cycle SHALL be ignored.
REQ-024 The counter SHALL be 32 bits wide. Because of the range check, no address wrap-around can occur.

Reset
REQ-025 reset=1 SHALL asynchronously force IDLE, clear i and all latched registers, and set busy=0, done=0 and err=0. disk_we and mem_we SHALL be 0 unless cpu_req=1.
REQ-026 Reset during XFER SHALL abort the transfer: no done pulse, and words already written remain written.

Structure
REQ-027 The state encoding and the default DISK_SIZE/MEM_SIZE constants SHALL live in the shared CPU package/header.
REQ-028 The CPU/DMA disk-port multiplexer SHALL be a sub-module named mux_porta_disco. The FSM and counter SHALL stay in controlador_dma_disco.

Verification
REQ-029 Disk preloaded with 5,6,7,8 at addresses 64..67; start with dir=0, disk_base=64, mem_base=0, length=4 -> memory words 0..3 = 5,6,7,8; busy high for 4 cycles; done pulses on cycle 5.
REQ-030 Memory words 10..11 = 0xAA,0xBB; start with dir=1, mem_base=10, disk_base=300, length=2 -> disk[300]=0xAA, disk[301]=0xBB; disk_we high for exactly 2 cycles.
REQ-031 Same transfer as REQ-029 with cpu_req=1, cpu_we=1, cpu_addr=400, cpu_data=0x55 in the 2nd XFER cycle -> disk[400]=0x55; no memory write that cycle; busy high for 5 cycles; memory data still correct.
REQ-032 start with disk_base=498, length=4 -> no writes; done=1 and err=1 in the cycle after start.
REQ-033 start with length=0 -> done=1 and err=0 next cycle, with no writes.
REQ-034 reset asserted mid-way through a length=4 transfer, after 2 words -> immediate IDLE with busy=0 and no done pulse; memory words 0..1 written and words 2..3 untouched; a new start afterwards is accepted.
